fir_tile_seq: RTL and testbench
===============================

// Module: fir_tile_seq
// PURPOSE
//  Frame sequencer for one tile of NUM_PE chained PEs (transposed FIR / auto mode).
//  Accepts a frame of input samples over a valid/ready stream and drives the
//  tile-wide PE control and data fields. Appends NUM_PE-1 zero samples to drain
//  the chain, then flushes it. Generates out_valid/out_last aligned to the last PE.
// PARAMETERS
//  NUM_PE   16  PEs in the tile chain (>=2)
//  DATA_W   32  complex sample width (16b I + 16b Q)
//  LEN_W    16  frame-length counter width
//  SHIFT_W   4  multiplier post-shift field width
// PORTS
//  clk            in   1        clock
//  rst            in   1        asynchronous reset, active-high
//  cfg_start      in   1        one-cycle pulse; latches cfg_* and starts a frame
//  cfg_frame_len  in   LEN_W    input samples in the frame (0 = start ignored)
//  cfg_is_auto    in   1        1 = auto mode (adder only), 0 = FIR mode
//  cfg_shift      in   SHIFT_W  multiplier shift for the frame
//  in_valid       in   1        upstream sample valid
//  in_ready       out  1        sequencer accepts a sample this cycle
//  in_sample      in   DATA_W   upstream sample
//  pe_valid       out  1        to PE tile_to_pe.valid
//  pe_enable      out  1        to PE tile_to_pe.enable
//  pe_flush       out  1        to PE tile_to_pe.flush
//  pe_is_auto     out  1        to PE tile_to_pe.is_auto
//  pe_shift       out  SHIFT_W  to PE tile_to_pe.shift
//  pe_sample      out  DATA_W   to PE tile_to_pe.input_sample
//  out_valid      out  1        last-PE to_next_pe holds a result this cycle
//  out_last       out  1        final result of the frame (with out_valid)
//  busy           out  1        state != IDLE
//  done           out  1        one-cycle pulse when the frame is fully finished
//  underrun       out  1        sticky: in_valid low during RUN; cleared by cfg_start
// BEHAVIOUR
//  Reset (async): state=IDLE; all outputs 0; counters and delay line cleared.
//  Reset mid-frame aborts at once: no done pulse, no flush issued.
//  All pe_* and out_* outputs are registered.
//  FSM: IDLE -> RUN -> DRAIN -> WAIT -> FLUSH -> IDLE.
//  IDLE:
//   - cfg_start with cfg_frame_len!=0 latches cfg, clears underrun, and goes to RUN.
//   - cfg_start with cfg_frame_len==0 is ignored. cfg_start when not IDLE is ignored.
//  RUN:
//   - in_ready=1 every cycle. One sample slot per cycle: the PE chain cannot stall.
//   - in_valid=1: pe_sample<=in_sample.
//   - in_valid=0: pe_sample<=0 and underrun<=1. The slot still counts.
//   - pe_valid=pe_enable=1 in the following cycle.
//   - After frame_len slots, go to DRAIN.
//  DRAIN:
//   - in_ready=0. Issue NUM_PE-1 slots with pe_sample=0, pe_valid=pe_enable=1.
//   - Then go to WAIT.
//  WAIT:
//   - pe_valid=pe_enable=0. Stay until the out_valid delay line is empty.
//  FLUSH:
//   - pe_flush=1 for exactly 1 cycle, pe_valid=0. done=1 in the same cycle.
//   - Next state is IDLE.
//  Latency: a slot issued in cycle c (pe_valid=1 in c) gives out_valid in c+2 (FIR)
//   or c+1 (auto). This matches the PE register depth: mult reg + add reg, or add reg only.
//  out_valid count per frame = frame_len+NUM_PE-1.
//  out_last is asserted with the out_valid of the last DRAIN slot.
//  pe_is_auto/pe_shift hold the latched cfg from RUN entry until the next start.
//  Counters: slot counter LEN_W bits; drain counter clog2(NUM_PE) bits. No wrap is
//   possible, since each counter is reloaded on entry to its state.
//  frame_len=1: RUN lasts 1 cycle, then DRAIN.
//  in_valid may go high in IDLE/DRAIN/WAIT/FLUSH; it is never accepted (in_ready=0).
// TESTING
//  T1 reset:
//   - Assert rst mid-RUN (NUM_PE=4, len=8, slot 3).
//   - All outputs 0 asynchronously; no done; next start runs a clean frame.
//  T2 FIR frame:
//   - NUM_PE=4, taps 1..4, len=4, samples 1,0,0,0 gap-free.
//   - 7 out_valid pulses, first 3 cycles after start accept.
//   - out_last on the 7th; done 1 cycle after WAIT empties; underrun=0.
//  T3 auto frame:
//   - len=5, cfg_is_auto=1.
//   - First out_valid 1 cycle earlier than T2 timing; 8 outputs; pe_is_auto=1 throughout.
//  T4 underrun:
//   - len=6, in_valid low on slot 2.
//   - pe_sample=0 that slot; underrun=1 sticky; still 9 outputs and done.
//  T5 ignored starts:
//   - cfg_start with len=0 in IDLE gives no busy.
//   - cfg_start during RUN leaves the latched cfg unchanged and the frame length unaffected.
//  T6 back-to-back:
//   - cfg_start in the cycle after done.
//   - pe_flush seen exactly once between frames; second frame outputs correct.

Source files
------------

// File: rtl/fir_tile_seq_if.sv
// Upstream sample stream into the tile sequencer: valid/ready handshake plus sample.
interface fir_tile_seq_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_sample;

  modport master (output in_valid, output in_sample, input in_ready);
  modport slave  (input in_valid, input in_sample, output in_ready);
endinterface

// File: rtl/fir_tile_seq.sv
// Frame sequencer for one tile of NUM_PE chained PEs: feeds samples, drains the
// chain with NUM_PE-1 zero slots, flushes, and tracks last-PE output validity.
module fir_tile_seq #(
  parameter int NUM_PE  = 16,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 16,
  parameter int SHIFT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_start,
  input  logic [LEN_W-1:0]   cfg_frame_len,
  input  logic               cfg_is_auto,
  input  logic [SHIFT_W-1:0] cfg_shift,
  fir_tile_seq_if.slave      in_if,
  output logic               pe_valid,
  output logic               pe_enable,
  output logic               pe_flush,
  output logic               pe_is_auto,
  output logic [SHIFT_W-1:0] pe_shift,
  output logic [DATA_W-1:0]  pe_sample,
  output logic               out_valid,
  output logic               out_last,
  output logic               busy,
  output logic               done,
  output logic               underrun
);

  localparam int DRN_W = $clog2(NUM_PE);
  localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(NUM_PE - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_WAIT  = 3'd3,
    S_FLUSH = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] slot_cnt;
  logic [DRN_W-1:0] drn_cnt;
  logic             start_ok;
  logic             issue;
  logic             last_issue;
  logic             in_ready_c;
  logic             pend;
  logic             last_p0;
  logic             vld_p1;
  logic             last_p1;

  // Chain still holds a slot that has not reached the last PE output register.
  assign pend = pe_valid | (~pe_is_auto & vld_p1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cfg_start && (cfg_frame_len != '0)) state_nxt = S_RUN;
      S_RUN:   if (slot_cnt == LEN_W'(1))              state_nxt = S_DRAIN;
      S_DRAIN: if (drn_cnt == DRN_W'(1))               state_nxt = S_WAIT;
      S_WAIT:  if (!pend)                              state_nxt = S_FLUSH;
      S_FLUSH:                                         state_nxt = S_IDLE;
      default:                                         state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    start_ok   = (state == S_IDLE) && cfg_start && (cfg_frame_len != '0);
    in_ready_c = (state == S_RUN);
    issue      = (state == S_RUN) || (state == S_DRAIN);
    last_issue = (state == S_DRAIN) && (drn_cnt == DRN_W'(1));
    busy       = (state != S_IDLE);
  end

  assign in_if.in_ready = in_ready_c;

  // p0: slot issue into the tile; counters and latched frame config
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt   <= '0;
      drn_cnt    <= '0;
      pe_valid   <= 1'b0;
      pe_enable  <= 1'b0;
      pe_sample  <= '0;
      pe_is_auto <= 1'b0;
      pe_shift   <= '0;
      pe_flush   <= 1'b0;
      done       <= 1'b0;
      underrun   <= 1'b0;
      last_p0    <= 1'b0;
    end else begin
      if (start_ok) begin
        slot_cnt   <= cfg_frame_len;
        pe_is_auto <= cfg_is_auto;
        pe_shift   <= cfg_shift;
      end else if (state == S_RUN) begin
        slot_cnt <= slot_cnt - LEN_W'(1);
      end

      if ((state == S_RUN) && (state_nxt == S_DRAIN)) drn_cnt <= DRN_LOAD;
      else if (state == S_DRAIN)                      drn_cnt <= drn_cnt - DRN_W'(1);

      if (start_ok)                                underrun <= 1'b0;
      else if ((state == S_RUN) && !in_if.in_valid) underrun <= 1'b1;

      pe_valid  <= issue;
      pe_enable <= issue;
      pe_sample <= ((state == S_RUN) && in_if.in_valid) ? in_if.in_sample : '0;
      last_p0   <= last_issue;
      pe_flush  <= (state_nxt == S_FLUSH);
      done      <= (state_nxt == S_FLUSH);
    end
  end

  // p1/p2: last-PE validity, one register deep in auto mode, two in FIR mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      vld_p1    <= pe_valid;
      last_p1   <= last_p0;
      out_valid <= pe_is_auto ? pe_valid : vld_p1;
      out_last  <= pe_is_auto ? last_p0  : last_p1;
    end
  end

endmodule

// File: tb/tb_fir_tile_seq.sv
// Scoreboard bench for fir_tile_seq with a 4-PE tile.
module tb_fir_tile_seq;
  localparam int NUM_PE  = 4;
  localparam int DATA_W  = 32;
  localparam int LEN_W   = 16;
  localparam int SHIFT_W = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cfg_start;
  logic [LEN_W-1:0]   cfg_frame_len;
  logic               cfg_is_auto;
  logic [SHIFT_W-1:0] cfg_shift;
  logic               pe_valid, pe_enable, pe_flush, pe_is_auto;
  logic [SHIFT_W-1:0] pe_shift;
  logic [DATA_W-1:0]  pe_sample;
  logic               out_valid, out_last, busy, done, underrun;

  fir_tile_seq_if #(.DATA_W(DATA_W)) in_if ();

  fir_tile_seq #(
    .NUM_PE(NUM_PE), .DATA_W(DATA_W), .LEN_W(LEN_W), .SHIFT_W(SHIFT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_frame_len(cfg_frame_len),
    .cfg_is_auto(cfg_is_auto), .cfg_shift(cfg_shift),
    .in_if(in_if),
    .pe_valid(pe_valid), .pe_enable(pe_enable), .pe_flush(pe_flush),
    .pe_is_auto(pe_is_auto), .pe_shift(pe_shift), .pe_sample(pe_sample),
    .out_valid(out_valid), .out_last(out_last), .busy(busy),
    .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic lst; } ov_t;
  typedef struct { int cyc; logic [DATA_W-1:0] smp; } pe_t;
  ov_t ov_q[$];
  pe_t pe_q[$];
  int  done_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  task automatic check_idle_outs(input string pfx);
    check_val({pfx, "_pe_valid"},   pe_valid,   0);
    check_val({pfx, "_pe_enable"},  pe_enable,  0);
    check_val({pfx, "_pe_flush"},   pe_flush,   0);
    check_val({pfx, "_pe_is_auto"}, pe_is_auto, 0);
    check_val({pfx, "_pe_shift"},   pe_shift,   0);
    check_val({pfx, "_pe_sample"},  pe_sample,  0);
    check_val({pfx, "_out_valid"},  out_valid,  0);
    check_val({pfx, "_out_last"},   out_last,   0);
    check_val({pfx, "_busy"},       busy,       0);
    check_val({pfx, "_done"},       done,       0);
    check_val({pfx, "_underrun"},   underrun,   0);
    check_val({pfx, "_in_ready"},   in_if.in_ready, 0);
  endtask

  // Cycle-by-cycle comparison of the registered outputs against the scoreboard
  bit                mon_en = 1'b0;
  bit                e_ov, e_pv, e_dn;
  logic              e_last;
  logic [DATA_W-1:0] e_smp;
  always @(negedge clk) begin
    if (mon_en) begin
      e_ov   = (ov_q.size() != 0) && (ov_q[0].cyc == cyc);
      e_last = e_ov ? ov_q[0].lst : 1'b0;
      if (e_ov) void'(ov_q.pop_front());
      check_val("out_valid", out_valid, e_ov);
      check_val("out_last",  out_last,  e_last);

      e_pv  = (pe_q.size() != 0) && (pe_q[0].cyc == cyc);
      e_smp = e_pv ? pe_q[0].smp : '0;
      if (e_pv) void'(pe_q.pop_front());
      check_val("pe_valid",  pe_valid,  e_pv);
      check_val("pe_enable", pe_enable, e_pv);
      check_val("pe_sample", pe_sample, e_smp);

      e_dn = (done_q.size() != 0) && (done_q[0] == cyc);
      if (e_dn) void'(done_q.pop_front());
      check_val("done",     done,     e_dn);
      check_val("pe_flush", pe_flush, e_dn);
    end
  end

  // Drives one frame starting in the current cycle; returns in the cycle after done.
  task automatic run_frame(input int len, input bit au, input logic [SHIFT_W-1:0] sh,
                           input int gap, input bit impulse, input bit mid_start);
    int s, lat, n;
    logic [DATA_W-1:0] smp;
    check_val("idle_busy", busy, 0);
    s   = cyc;
    lat = au ? 1 : 2;
    cfg_start     = 1'b1;
    cfg_frame_len = LEN_W'(len);
    cfg_is_auto   = au;
    cfg_shift     = sh;
    for (int i = 0; i < len + NUM_PE - 1; i++) begin
      ov_t o;
      o.cyc = s + 2 + i + lat;
      o.lst = (i == len + NUM_PE - 2);
      ov_q.push_back(o);
    end
    done_q.push_back(s + len + NUM_PE + lat + 1);
    @(posedge clk); #1;
    cfg_start = 1'b0;
    for (int i = 0; i < len; i++) begin
      pe_t p;
      check_val("run_in_ready", in_if.in_ready, 1);
      check_val("run_is_auto", pe_is_auto, au);
      check_val("run_shift", pe_shift, sh);
      smp = impulse ? ((i == 0) ? 32'd1 : 32'd0) : $urandom();
      in_if.in_valid  = (i != gap);
      in_if.in_sample = smp;
      p.cyc = s + 2 + i;
      p.smp = (i != gap) ? smp : '0;
      pe_q.push_back(p);
      if (mid_start && i == 1) begin
        cfg_start     = 1'b1;
        cfg_frame_len = LEN_W'(2);
        cfg_is_auto   = ~au;
        cfg_shift     = ~sh;
      end
      @(posedge clk); #1;
      cfg_start = 1'b0;
    end
    for (int j = 0; j < NUM_PE - 1; j++) begin
      pe_t p;
      p.cyc = s + 2 + len + j;
      p.smp = '0;
      pe_q.push_back(p);
    end
    // upstream offers data during DRAIN; it must not reach the chain
    in_if.in_valid  = 1'b1;
    in_if.in_sample = 32'hDEAD_BEEF;
    check_val("drain_in_ready", in_if.in_ready, 0);
    check_val("drain_busy", busy, 1);
    n = 0;
    while (done_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      in_if.in_valid = 1'b0;
      n++;
    end
    if (done_q.size() != 0) begin
      check_val("done_timeout", 0, 1);
      ov_q.delete(); pe_q.delete(); done_q.delete();
    end
    in_if.in_valid = 1'b0;
    check_val("end_underrun", underrun, (gap >= 0 && gap < len));
    check_val("end_is_auto", pe_is_auto, au);
    check_val("end_shift", pe_shift, sh);
  endtask

  initial begin
    cfg_start       = 1'b0;
    cfg_frame_len   = '0;
    cfg_is_auto     = 1'b0;
    cfg_shift       = '0;
    in_if.in_valid  = 1'b0;
    in_if.in_sample = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outs("rst");
    rst = 1'b0;

    // T1: reset asserted in slot 3 of an 8-sample auto frame
    @(posedge clk); #1;
    cfg_start = 1'b1; cfg_frame_len = 16'd8; cfg_is_auto = 1'b1; cfg_shift = 4'd5;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_if.in_valid  = (i != 0);
      in_if.in_sample = $urandom() | 32'h1;
      @(posedge clk); #1;
    end
    in_if.in_valid = 1'b1;
    check_val("t1_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1 check_idle_outs("t1");
    repeat (3) begin
      @(posedge clk); #1;
      check_val("t1_no_done", done, 0);
    end
    rst = 1'b0;
    in_if.in_valid = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // T2: FIR impulse frame
    run_frame(4, 1'b0, 4'd3, -1, 1'b1, 1'b0);
    // T3: auto frame
    run_frame(5, 1'b1, 4'd7, -1, 1'b0, 1'b0);
    // T4: underrun on slot 2
    run_frame(6, 1'b0, 4'd2, 2, 1'b0, 1'b0);

    // T5: zero-length start ignored, then start during RUN ignored
    cfg_start = 1'b1; cfg_frame_len = '0; cfg_is_auto = 1'b1; cfg_shift = 4'hF;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    check_val("len0_busy", busy, 0);
    @(posedge clk); #1;
    check_val("len0_busy2", busy, 0);
    run_frame(5, 1'b0, 4'd9, -1, 1'b0, 1'b1);

    // T6: back-to-back frames, second starts in the cycle after done
    run_frame(3, 1'b1, 4'd1, -1, 1'b0, 1'b0);
    run_frame(4, 1'b0, 4'd6, 0, 1'b0, 1'b0);
    run_frame(2, 1'b0, 4'd4, -1, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    check_val("ov_q_empty", ov_q.size(), 0);
    check_val("pe_q_empty", pe_q.size(), 0);
    check_val("final_busy", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
